// File: rtl/mem_responder.sv
// Single-outstanding memory responder.
// Word-organised RAM with programmable access latency and error detection.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          a_we;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;
  logic          a_err;
  logic [AW-1:0] a_idx;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-latency accesses use the live request, otherwise the latched one.
  always_comb begin
    a_we    = accept ? req_we    : we_q;
    a_addr  = accept ? req_addr  : addr_q;
    a_wdata = accept ? req_wdata : wdata_q;
    a_be    = accept ? req_be    : be_q;
    a_err   = (a_addr[1:0] != 2'b00) ||
              ({2'b00, a_addr[31:2]} >= 32'(DEPTH));
    a_idx   = a_addr[AW+1:2];
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = a_err;
      rdata_d = (a_err || a_we) ? 32'h0 : mem_q[a_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Memory contents survive reset; commit happens only on RESP entry.
  always_ff @(posedge clk) begin
    if (enter_resp && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem_q[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=2 and LATENCY=0 instances
// checked against a transaction-level model every cycle.
module tb_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_err;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int latof(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Transaction-level model: byte store plus one pending request per DUT.
  logic [7:0]  mb [longint];
  bit          busy [2];
  int          age  [2];
  logic        pw   [2];
  logic [31:0] pa   [2];
  logic [31:0] pd   [2];
  logic [3:0]  pb   [2];
  logic [31:0] erd  [2];
  logic        eer  [2];
  bit          ekn  [2];

  task automatic commit(input int d);
    longint base;
    base = (longint'(d) << 32) + longint'(pa[d]);
    eer[d] = (pa[d][1:0] != 2'b00) || ((pa[d] >> 2) >= DEPTH);
    erd[d] = 32'h0;
    ekn[d] = 1'b1;
    if (!eer[d] && pw[d]) begin
      for (int i = 0; i < 4; i++)
        if (pb[d][i]) mb[base + i] = pd[d][8*i +: 8];
    end else if (!eer[d]) begin
      for (int i = 0; i < 4; i++) begin
        if (mb.exists(base + i)) erd[d][8*i +: 8] = mb[base + i];
        else ekn[d] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy[0] = 1'b0;
      busy[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!busy[d]) begin
          if (req_valid[d]) begin
            busy[d] = 1'b1;
            age[d]  = 0;
            pw[d]   = req_we[d];
            pa[d]   = req_addr[d];
            pd[d]   = req_wdata[d];
            pb[d]   = req_be[d];
            if (latof(d) == 0) commit(d);
          end
        end else if (age[d] >= latof(d) && rsp_ready[d]) begin
          busy[d] = 1'b0;
        end else begin
          age[d]++;
          if (age[d] == latof(d)) commit(d);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic ev;
      ev = busy[d] && (age[d] >= latof(d));
      chk($sformatf("req_ready[%0d]", d), req_ready[d], !busy[d]);
      chk($sformatf("rsp_valid[%0d]", d), rsp_valid[d], ev);
      if (ev) begin
        chk($sformatf("rsp_err[%0d]", d), rsp_err[d], eer[d]);
        if (ekn[d])
          chk($sformatf("rsp_rdata[%0d]", d), rsp_rdata[d], erd[d]);
      end
    end
  end

  // Called at a negedge; returns at a negedge after the response handshake.
  task automatic xact(input int d, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input int hold, output logic [31:0] rd,
                      output logic er, output int lat, output int acc);
    int n;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait req_ready", req_ready[d], 1'b1);
    rsp_ready[d] = (hold == 0);
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[d] && lat < 40);
    chk("wait rsp_valid", rsp_valid[d], 1'b1);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      req_we[d]    = 1'b1;
      req_addr[d]  = 32'h10;
      req_wdata[d] = 32'h0;
      req_be[d]    = 4'hF;
      req_valid[d] = 1'b1;
      @(negedge clk);
      chk("hold rsp_valid", rsp_valid[d], 1'b1);
      chk("hold rsp_rdata", rsp_rdata[d], rd);
      chk("hold rsp_err", rsp_err[d], er);
      chk("hold req_ready", req_ready[d], 1'b0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_vals(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, " req_ready"}, req_ready[d], 1'b1);
      chk({nm, " rsp_valid"}, rsp_valid[d], 1'b0);
      chk({nm, " rsp_rdata"}, rsp_rdata[d], 32'h0);
      chk({nm, " rsp_err"}, rsp_err[d], 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, a1, a2;

    rst_n     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    rsp_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
    end
    #2 rst_n = 1'b0;
    #1 reset_vals("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, a1);
    chk("wr10 err", er, 1'b0);
    chk("wr10 rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, a1);
    chk("rd10 rdata", rd, 32'hDEADBEEF);
    chk("rd10 err", er, 1'b0);
    chk("rd10 latency", lat, 32'd3);

    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, rd, er, lat, a1);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, a1);
    chk("rd10 merged", rd, 32'hDEADBEAA);

    xact(0, 1'b0, 32'h12, 32'h0, 4'hF, 0, rd, er, lat, a1);
    chk("rd12 err", er, 1'b1);
    chk("rd12 rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h1000, 32'h0, 4'hF, 0, rd, er, lat, a1);
    chk("rd1000 err", er, 1'b1);

    xact(0, 1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 0, rd, er, lat, a1);
    chk("wrFFC err", er, 1'b0);
    xact(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, a1);
    chk("wr1000 err", er, 1'b1);
    xact(0, 1'b1, 32'hFFC, 32'h0, 4'h0, 0, rd, er, lat, a1);
    chk("wrFFC be0 err", er, 1'b0);
    xact(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 0, rd, er, lat, a1);
    chk("rdFFC intact", rd, 32'h5A5A5A5A);

    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat, a1);
    chk("hold rd10", rd, 32'hDEADBEAA);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, a1);
    chk("rd10 after hold", rd, 32'hDEADBEAA);

    xact(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 0, rd, er, lat, a1);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, a2);
    chk("lat2 throughput", a2 - a1, 32'd4);

    xact(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, 0, rd, er, lat, a1);
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, a1);
    chk("rd20 pre", rd, 32'h0BADF00D);
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h12345678;
    req_be[0]    = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_vals("midwait");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, a1);
    chk("rd20 post reset", rd, 32'h0BADF00D);

    xact(1, 1'b1, 32'h8, 32'h11223344, 4'hF, 0, rd, er, lat, a1);
    chk("l0 wr latency", lat, 32'd1);
    xact(1, 1'b0, 32'h8, 32'h0, 4'hF, 0, rd, er, lat, a1);
    chk("l0 rd8", rd, 32'h11223344);
    chk("l0 rd latency", lat, 32'd1);
    xact(1, 1'b1, 32'h8, 32'h99000000, 4'h8, 0, rd, er, lat, a2);
    chk("l0 throughput", a2 - a1, 32'd2);
    xact(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat, a1);
    chk("l0 rd8 merged", rd, 32'h99223344);
    xact(1, 1'b0, 32'hA, 32'h0, 4'hF, 0, rd, er, lat, a1);
    chk("l0 rdA err", er, 1'b1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
